// File: rtl/asrv32_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: one-hot field
// widths and bit positions, 7-bit major opcodes, funct3 codes, the FIFO
// payload type and a small immediate-range helper.
package asrv32_encoder_pkg;

    localparam int OPCODE_WIDTH = 11;
    localparam int ALU_WIDTH    = 14;

    // one-hot bit positions of i_opcode
    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    // one-hot bit positions of i_alu_op
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic        illegal;
        logic [31:0] inst;
    } enc_entry_t;

    // true when v survives truncation to a bits-wide two's complement value
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] sh;
        sh = $signed(v) >>> (bits - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/asrv32_encoder_if.sv
// Encoder bus: decoded-field input handshake, encoded-word output
// handshake and the emitted-instruction counter.
// master = field producer / word consumer, slave = encoder.
interface asrv32_encoder_if #(parameter int CNT_W = 16);
    import asrv32_encoder_pkg::*;

    logic                    i_in_valid;
    logic                    o_in_ready;
    logic [OPCODE_WIDTH-1:0] i_opcode;
    logic [ALU_WIDTH-1:0]    i_alu_op;
    logic [2:0]              i_funct3;
    logic [4:0]              i_rs1_addr;
    logic [4:0]              i_rs2_addr;
    logic [4:0]              i_rd_addr;
    logic [31:0]             i_imm;
    logic                    o_out_valid;
    logic                    i_out_ready;
    logic [31:0]             o_inst;
    logic                    o_illegal;
    logic [CNT_W-1:0]        o_count;

    modport master (
        output i_in_valid, i_opcode, i_alu_op, i_funct3, i_rs1_addr,
               i_rs2_addr, i_rd_addr, i_imm, i_out_ready,
        input  o_in_ready, o_out_valid, o_inst, o_illegal, o_count
    );

    modport slave (
        input  i_in_valid, i_opcode, i_alu_op, i_funct3, i_rs1_addr,
               i_rs2_addr, i_rd_addr, i_imm, i_out_ready,
        output o_in_ready, o_out_valid, o_inst, o_illegal, o_count
    );

endinterface

// File: rtl/asrv32_enc_fifo2.sv
// Two-entry FIFO decoupling the encoder from its consumer. The caller
// never pushes while full nor pops while empty; pointers are single bits.
module asrv32_enc_fifo2 #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (occupancy != 2'd0);
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    // pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push_valid) wr_ptr <= ~wr_ptr;
            if (pop)        rd_ptr <= ~rd_ptr;
            occupancy <= occupancy + {1'b0, push_valid} - {1'b0, pop};
        end
    end

    // storage needs no reset: reads are masked to zero while empty
    always_ff @(posedge i_clk) begin
        if (push_valid) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/asrv32_encoder.sv
// Packs decoded RV32I fields back into a 32-bit instruction word.
// Optional immediate range checking is enabled by defining
// ASRV32_ENC_RANGECHK_EN; otherwise out-of-range bits are truncated.
module asrv32_encoder
    import asrv32_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    asrv32_encoder_if.slave   bus
);

`ifdef ASRV32_ENC_RANGECHK_EN
    localparam bit RANGECHK = 1'b1;
`else
    localparam bit RANGECHK = 1'b0;
`endif

    localparam logic [OPCODE_WIDTH-1:0] OH_RTYPE  = OPCODE_WIDTH'(1) << OP_RTYPE;
    localparam logic [OPCODE_WIDTH-1:0] OH_ITYPE  = OPCODE_WIDTH'(1) << OP_ITYPE;
    localparam logic [OPCODE_WIDTH-1:0] OH_LOAD   = OPCODE_WIDTH'(1) << OP_LOAD;
    localparam logic [OPCODE_WIDTH-1:0] OH_STORE  = OPCODE_WIDTH'(1) << OP_STORE;
    localparam logic [OPCODE_WIDTH-1:0] OH_BRANCH = OPCODE_WIDTH'(1) << OP_BRANCH;
    localparam logic [OPCODE_WIDTH-1:0] OH_JAL    = OPCODE_WIDTH'(1) << OP_JAL;
    localparam logic [OPCODE_WIDTH-1:0] OH_JALR   = OPCODE_WIDTH'(1) << OP_JALR;
    localparam logic [OPCODE_WIDTH-1:0] OH_LUI    = OPCODE_WIDTH'(1) << OP_LUI;
    localparam logic [OPCODE_WIDTH-1:0] OH_AUIPC  = OPCODE_WIDTH'(1) << OP_AUIPC;
    localparam logic [OPCODE_WIDTH-1:0] OH_SYSTEM = OPCODE_WIDTH'(1) << OP_SYSTEM;
    localparam logic [OPCODE_WIDTH-1:0] OH_FENCE  = OPCODE_WIDTH'(1) << OP_FENCE;

    localparam logic [ALU_WIDTH-1:0] AH_ADD  = ALU_WIDTH'(1) << ALU_ADD;
    localparam logic [ALU_WIDTH-1:0] AH_SUB  = ALU_WIDTH'(1) << ALU_SUB;
    localparam logic [ALU_WIDTH-1:0] AH_SLT  = ALU_WIDTH'(1) << ALU_SLT;
    localparam logic [ALU_WIDTH-1:0] AH_SLTU = ALU_WIDTH'(1) << ALU_SLTU;
    localparam logic [ALU_WIDTH-1:0] AH_XOR  = ALU_WIDTH'(1) << ALU_XOR;
    localparam logic [ALU_WIDTH-1:0] AH_OR   = ALU_WIDTH'(1) << ALU_OR;
    localparam logic [ALU_WIDTH-1:0] AH_AND  = ALU_WIDTH'(1) << ALU_AND;
    localparam logic [ALU_WIDTH-1:0] AH_SLL  = ALU_WIDTH'(1) << ALU_SLL;
    localparam logic [ALU_WIDTH-1:0] AH_SRL  = ALU_WIDTH'(1) << ALU_SRL;
    localparam logic [ALU_WIDTH-1:0] AH_SRA  = ALU_WIDTH'(1) << ALU_SRA;
    localparam logic [ALU_WIDTH-1:0] AH_EQ   = ALU_WIDTH'(1) << ALU_EQ;
    localparam logic [ALU_WIDTH-1:0] AH_NEQ  = ALU_WIDTH'(1) << ALU_NEQ;
    localparam logic [ALU_WIDTH-1:0] AH_GE   = ALU_WIDTH'(1) << ALU_GE;
    localparam logic [ALU_WIDTH-1:0] AH_GEU  = ALU_WIDTH'(1) << ALU_GEU;

    logic             ready_q;
    logic             push;
    logic [1:0]       occupancy;
    enc_entry_t       push_data;
    enc_entry_t       pop_data;
    logic             pop_valid;
    logic [CNT_W-1:0] count;

    logic [31:0] imm;
    logic [2:0]  alu_f3;
    logic        alu_alt;
    logic        alu_r_ok;
    logic        alu_shift;
    logic [2:0]  br_f3;
    logic        br_ok;
    logic [31:0] raw;
    logic        bad;

    assign imm = bus.i_imm;

    // ALU-op to funct3 for register/immediate and branch forms
    always_comb begin
        alu_f3    = F3_ADD_SUB;
        alu_alt   = 1'b0;
        alu_r_ok  = 1'b1;
        alu_shift = 1'b0;
        br_f3     = F3_BEQ;
        br_ok     = 1'b1;
        case (bus.i_alu_op)
            AH_ADD:  alu_f3 = F3_ADD_SUB;
            AH_SUB:  alu_alt = 1'b1;
            AH_SLT:  alu_f3 = F3_SLT;
            AH_SLTU: alu_f3 = F3_SLTU;
            AH_XOR:  alu_f3 = F3_XOR;
            AH_OR:   alu_f3 = F3_OR;
            AH_AND:  alu_f3 = F3_AND;
            AH_SLL:  begin alu_f3 = F3_SLL;     alu_shift = 1'b1; end
            AH_SRL:  begin alu_f3 = F3_SRL_SRA; alu_shift = 1'b1; end
            AH_SRA:  begin alu_f3 = F3_SRL_SRA; alu_shift = 1'b1; alu_alt = 1'b1; end
            default: alu_r_ok = 1'b0;
        endcase
        case (bus.i_alu_op)
            AH_EQ:   br_f3 = F3_BEQ;
            AH_NEQ:  br_f3 = F3_BNE;
            AH_SLT:  br_f3 = F3_BLT;
            AH_GE:   br_f3 = F3_BGE;
            AH_SLTU: br_f3 = F3_BLTU;
            AH_GEU:  br_f3 = F3_BGEU;
            default: br_ok = 1'b0;
        endcase
    end

    // pack fields by instruction format; any violation zeroes the word
    always_comb begin
        raw = '0;
        bad = 1'b0;
        case (bus.i_opcode)
            OH_RTYPE: begin
                bad = !alu_r_ok;
                raw = {alu_alt ? F7_ALT : 7'b0, bus.i_rs2_addr, bus.i_rs1_addr,
                       alu_f3, bus.i_rd_addr, OPC_RTYPE};
            end
            OH_ITYPE: begin
                bad = !alu_r_ok || (bus.i_alu_op == AH_SUB);
                if (alu_shift) begin
                    raw = {alu_alt ? F7_ALT : 7'b0, imm[4:0], bus.i_rs1_addr,
                           alu_f3, bus.i_rd_addr, OPC_ITYPE};
                    if (RANGECHK && imm[11:5] != 7'b0) bad = 1'b1;
                end else begin
                    raw = {imm[11:0], bus.i_rs1_addr, alu_f3, bus.i_rd_addr, OPC_ITYPE};
                    if (RANGECHK && !fits_signed(imm, 12)) bad = 1'b1;
                end
            end
            OH_LOAD, OH_JALR, OH_SYSTEM, OH_FENCE: begin
                unique case (bus.i_opcode)
                    OH_LOAD:   raw[6:0] = OPC_LOAD;
                    OH_JALR:   raw[6:0] = OPC_JALR;
                    OH_SYSTEM: raw[6:0] = OPC_SYSTEM;
                    default:   raw[6:0] = OPC_FENCE;
                endcase
                raw[31:7] = {imm[11:0], bus.i_rs1_addr, bus.i_funct3, bus.i_rd_addr};
                // fence carries pred/succ bits here, so it is not range-checked
                if (RANGECHK && bus.i_opcode != OH_FENCE && !fits_signed(imm, 12)) bad = 1'b1;
            end
            OH_STORE: begin
                raw = {imm[11:5], bus.i_rs2_addr, bus.i_rs1_addr, bus.i_funct3,
                       imm[4:0], OPC_STORE};
                if (RANGECHK && !fits_signed(imm, 12)) bad = 1'b1;
            end
            OH_BRANCH: begin
                bad = !br_ok;
                raw = {imm[12], imm[10:5], bus.i_rs2_addr, bus.i_rs1_addr, br_f3,
                       imm[4:1], imm[11], OPC_BRANCH};
                if (RANGECHK && (!fits_signed(imm, 13) || imm[0])) bad = 1'b1;
            end
            OH_JAL: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], bus.i_rd_addr, OPC_JAL};
                if (RANGECHK && (!fits_signed(imm, 21) || imm[0])) bad = 1'b1;
            end
            OH_LUI, OH_AUIPC: begin
                raw = {imm[31:12], bus.i_rd_addr,
                       (bus.i_opcode == OH_LUI) ? OPC_LUI : OPC_AUIPC};
                if (RANGECHK && imm[11:0] != 12'b0) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        push_data.illegal = bad;
        push_data.inst    = bad ? 32'b0 : raw;
    end

    // input ready is held low through reset and rises on the first edge after
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    assign bus.o_in_ready = ready_q && (occupancy != 2'd2);
    assign push           = bus.i_in_valid && bus.o_in_ready;

    asrv32_enc_fifo2 #(.W($bits(enc_entry_t))) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .push_valid (push),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (bus.i_out_ready),
        .pop_data   (pop_data),
        .occupancy  (occupancy)
    );

    assign bus.o_out_valid = pop_valid;
    assign bus.o_inst      = pop_data.inst;
    assign bus.o_illegal   = pop_data.illegal;

    // count words taken by the consumer, wrapping naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          count <= '0;
        else if (pop_valid && bus.i_out_ready) count <= count + 1'b1;
    end

    assign bus.o_count = count;

endmodule

// File: tb/tb_asrv32_encoder.sv
// Self-checking bench for asrv32_encoder: directed cases followed by
// randomized traffic against a field-level reference model and a queue.
// Honors ASRV32_ENC_RANGECHK_EN the same way the design does.
module tb_asrv32_encoder;

    typedef struct {
        logic [10:0] op;
        logic [13:0] alu;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } fields_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;

    asrv32_encoder_if #(.CNT_W(16)) bus ();

    asrv32_encoder #(.CNT_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] q[$];
    logic [15:0] exp_count = 0;
    logic        ready_ok = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: build the word from field tables with plain arithmetic
    function automatic logic [32:0] model(input fields_t f);
        logic [31:0] opc [11] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h6F,
                                  32'h67, 32'h37, 32'h17, 32'h73, 32'h0F};
        int rf3 [10] = '{0, 0, 2, 3, 4, 6, 7, 1, 5, 5};
        int bf3 [14] = '{-1, -1, 4, 6, -1, -1, -1, -1, -1, -1, 0, 1, 5, 7};
        int t = -1;
        int a = -1;
        logic [31:0] imm = f.imm;
        logic [31:0] rd  = 32'(f.rd);
        logic [31:0] rs1 = 32'(f.rs1);
        logic [31:0] rs2 = 32'(f.rs2);
        logic [31:0] f3  = 32'(f.f3);
        logic [31:0] w   = 0;
        int s = int'(f.imm);
        bit bad = 0;
        bit rng = 0;
        if ($countones(f.op) == 1)
            for (int i = 0; i < 11; i++) if (f.op[i]) t = i;
        if ($countones(f.alu) == 1)
            for (int i = 0; i < 14; i++) if (f.alu[i]) a = i;
        if (t < 0) return {1'b1, 32'h0};
        case (t)
            0: begin
                if (a < 0 || a > 9) bad = 1;
                else w = opc[0] + (rd << 7) + (32'(rf3[a]) << 12) + (rs1 << 15) + (rs2 << 20)
                         + ((a == 1 || a == 9) ? 32'h4000_0000 : 0);
            end
            1: begin
                if (a < 0 || a > 9 || a == 1) bad = 1;
                else if (a >= 7) begin
                    w = opc[1] + (rd << 7) + (32'(rf3[a]) << 12) + (rs1 << 15)
                        + ((imm % 32) << 20) + ((a == 9) ? 32'h4000_0000 : 0);
                    rng = ((imm / 32) % 128) != 0;
                end else begin
                    w = opc[1] + (rd << 7) + (32'(rf3[a]) << 12) + (rs1 << 15) + ((imm % 4096) << 20);
                    rng = s < -2048 || s > 2047;
                end
            end
            2, 6, 9, 10: begin
                w = opc[t] + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm % 4096) << 20);
                rng = (t != 10) && (s < -2048 || s > 2047);
            end
            3: begin
                w = opc[3] + ((imm % 32) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
                    + (((imm / 32) % 128) << 25);
                rng = s < -2048 || s > 2047;
            end
            4: begin
                if (a < 0 || bf3[a] < 0) bad = 1;
                else w = opc[4] + (((imm / 2048) % 2) << 7) + (((imm / 2) % 16) << 8)
                         + (32'(bf3[a]) << 12) + (rs1 << 15) + (rs2 << 20)
                         + (((imm / 32) % 64) << 25) + (((imm / 4096) % 2) << 31);
                rng = s < -4096 || s > 4095 || (imm % 2) != 0;
            end
            5: begin
                w = opc[5] + (rd << 7) + (((imm / 4096) % 256) << 12) + (((imm / 2048) % 2) << 20)
                    + (((imm / 2) % 1024) << 21) + (((imm / 1048576) % 2) << 31);
                rng = s < -1048576 || s > 1048575 || (imm % 2) != 0;
            end
            default: begin
                w = opc[t] + (rd << 7) + (imm - (imm % 4096));
                rng = (imm % 4096) != 0;
            end
        endcase
`ifdef ASRV32_ENC_RANGECHK_EN
        if (rng) bad = 1;
`else
        rng = 0;
`endif
        if (bad) return {1'b1, 32'h0};
        return {1'b0, w};
    endfunction

    function automatic fields_t mk(input int op_i, input int alu_i, input int rd,
                                   input int rs1, input int rs2, input int imm);
        fields_t f;
        f.op = '0;
        f.alu = '0;
        if (op_i >= 0) f.op[op_i] = 1'b1;
        if (alu_i >= 0) f.alu[alu_i] = 1'b1;
        f.f3  = 3'd0;
        f.rd  = 5'(rd);
        f.rs1 = 5'(rs1);
        f.rs2 = 5'(rs2);
        f.imm = 32'(imm);
        return f;
    endfunction

    // one clock: verify outputs, drive inputs, advance the model at the edge
    task automatic do_cycle(input logic v, input fields_t f, input logic ordy);
        bit push;
        bit pop;
        check_val("out_valid", 64'(bus.o_out_valid), 64'(q.size() > 0));
        check_val("in_ready", 64'(bus.o_in_ready), 64'(ready_ok && q.size() < 2));
        check_val("count", 64'(bus.o_count), 64'(exp_count));
        if (q.size() > 0) begin
            check_val("inst", 64'(bus.o_inst), 64'(q[0][31:0]));
            check_val("illegal", 64'(bus.o_illegal), 64'(q[0][32]));
        end else begin
            check_val("inst_empty", 64'(bus.o_inst), 64'h0);
        end
        bus.i_in_valid  = v;
        bus.i_opcode    = f.op;
        bus.i_alu_op    = f.alu;
        bus.i_funct3    = f.f3;
        bus.i_rs1_addr  = f.rs1;
        bus.i_rs2_addr  = f.rs2;
        bus.i_rd_addr   = f.rd;
        bus.i_imm       = f.imm;
        bus.i_out_ready = ordy;
        push = v && ready_ok && q.size() < 2;
        pop  = q.size() > 0 && ordy;
        @(posedge i_clk);
        if (pop) begin
            void'(q.pop_front());
            exp_count++;
        end
        if (push) q.push_back(model(f));
        ready_ok = 1'b1;
        @(negedge i_clk);
    endtask

    function automatic fields_t rnd_fields();
        fields_t f;
        f.op  = ($urandom_range(0, 9) == 0) ? 11'($urandom) : (11'(1) << $urandom_range(0, 10));
        f.alu = ($urandom_range(0, 9) == 0) ? 14'($urandom) : (14'(1) << $urandom_range(0, 13));
        f.f3  = 3'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.rd  = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       f.imm = 32'($urandom_range(0, 63)) - 32'd32;
            1:       f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       f.imm = $urandom & 32'hFFFF_F000;
            default: f.imm = $urandom;
        endcase
        return f;
    endfunction

    initial begin
        fields_t idle;
        fields_t a;
        fields_t b;
        fields_t c;
        logic [15:0] base;
        idle = mk(-1, -1, 0, 0, 0, 0);
        bus.i_in_valid = 1'b0;
        bus.i_opcode = '0;
        bus.i_alu_op = '0;
        bus.i_funct3 = '0;
        bus.i_rs1_addr = '0;
        bus.i_rs2_addr = '0;
        bus.i_rd_addr = '0;
        bus.i_imm = '0;
        bus.i_out_ready = 1'b0;

        // reset state, and ready stays low across an edge in reset
        #2;
        check_val("rst_in_ready", 64'(bus.o_in_ready), 64'h0);
        check_val("rst_out_valid", 64'(bus.o_out_valid), 64'h0);
        check_val("rst_inst", 64'(bus.o_inst), 64'h0);
        check_val("rst_illegal", 64'(bus.o_illegal), 64'h0);
        check_val("rst_count", 64'(bus.o_count), 64'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        check_val("rst_in_ready_hold", 64'(bus.o_in_ready), 64'h0);
        i_rst_n = 1'b1;
        ready_ok = 1'b0;
        do_cycle(1'b0, idle, 1'b0);

        // directed encodings, each visible one cycle after accept
        do_cycle(1'b1, mk(0, 0, 1, 2, 3, 0), 1'b0);
        check_val("radd_inst", 64'(bus.o_inst), 64'h003100B3);
        check_val("radd_illegal", 64'(bus.o_illegal), 64'h0);
        do_cycle(1'b0, idle, 1'b1);
        do_cycle(1'b1, mk(1, 9, 5, 6, 0, 3), 1'b0);
        check_val("isra_inst", 64'(bus.o_inst), 64'h40335293);
        do_cycle(1'b0, idle, 1'b1);
        do_cycle(1'b1, mk(4, 10, 0, 1, 2, -4), 1'b0);
        check_val("beq_inst", 64'(bus.o_inst), 64'hFE208EE3);
        do_cycle(1'b0, idle, 1'b1);

        // back-pressure: two accepts fill the FIFO, third waits
        base = exp_count;
        a = mk(0, 4, 7, 8, 9, 0);
        b = mk(7, -1, 10, 0, 0, 32'h1234_5000);
        c = mk(5, -1, 1, 0, 0, 2048);
        do_cycle(1'b1, a, 1'b0);
        do_cycle(1'b1, b, 1'b0);
        check_val("full_in_ready", 64'(bus.o_in_ready), 64'h0);
        do_cycle(1'b1, c, 1'b0);
        check_val("full_hold_inst", 64'(bus.o_inst), 64'(model(a)));
        do_cycle(1'b1, c, 1'b1);
        check_val("order_b", 64'(bus.o_inst), 64'(model(b)));
        do_cycle(1'b1, c, 1'b1);
        do_cycle(1'b0, idle, 1'b1);
        check_val("bp_count", 64'(bus.o_count), 64'(base + 16'd3));

        // illegal inputs still occupy a slot and are counted
        do_cycle(1'b1, mk(-1, 0, 1, 2, 3, 0), 1'b0);
        check_val("noop_inst", 64'(bus.o_inst), 64'h0);
        check_val("noop_illegal", 64'(bus.o_illegal), 64'h1);
        do_cycle(1'b1, mk(1, 1, 1, 2, 0, 5), 1'b1);
        check_val("isub_illegal", 64'(bus.o_illegal), 64'h1);
        do_cycle(1'b0, idle, 1'b1);

        // immediate 2048 on an I-type add
        do_cycle(1'b1, mk(1, 0, 0, 0, 0, 2048), 1'b0);
`ifdef ASRV32_ENC_RANGECHK_EN
        check_val("imm2048_illegal", 64'(bus.o_illegal), 64'h1);
`else
        check_val("imm2048_inst", 64'(bus.o_inst), 64'h80000013);
`endif
        do_cycle(1'b0, idle, 1'b1);

        // asynchronous reset with two entries queued
        do_cycle(1'b1, a, 1'b0);
        do_cycle(1'b1, b, 1'b0);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(bus.o_out_valid), 64'h0);
        check_val("arst_count", 64'(bus.o_count), 64'h0);
        check_val("arst_in_ready", 64'(bus.o_in_ready), 64'h0);
        check_val("arst_inst", 64'(bus.o_inst), 64'h0);
        q.delete();
        exp_count = 0;
        ready_ok = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        do_cycle(1'b0, idle, 1'b1);
        do_cycle(1'b0, idle, 1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++)
            do_cycle(1'($urandom_range(0, 3) != 0), rnd_fields(), 1'($urandom_range(0, 2) != 0));
        for (int n = 0; n < 4; n++) do_cycle(1'b0, idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
